uart_sync_frame_tx: RTL and testbench

Initiator-side frame transmitter for the UART register-sync link. On a start request it reads a contiguous range of 32-bit registers from a local register bank and sends each register as one 7-byte sync frame over a single UART TX line. The remote register-sync memory receives these frames and applies the writes. The block contains its own 8N1 serializer and baud divider.

---
 rtl/uart_sync_frame_tx_if.sv | 25 ++
 rtl/uart_sync_frame_tx.sv | 134 +++++++++++++
 tb/tb_uart_sync_frame_tx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sync_frame_tx_if.sv
// Request, register-read and serial-line signals of the sync frame transmitter.
// The slave modport is the transmitter; the master modport is its environment.
interface uart_sync_frame_tx_if;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  count;
    logic        busy;
    logic        done;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        uart_txd;
    logic [15:0] frames_sent;

    modport slave (
        input  start, start_addr, count, rd_valid, rd_data,
        output busy, done, rd_req, rd_addr, uart_txd, frames_sent
    );

    modport master (
        output start, start_addr, count, rd_valid, rd_data,
        input  busy, done, rd_req, rd_addr, uart_txd, frames_sent
    );
endinterface

// File: rtl/uart_sync_frame_tx.sv
// Reads a range of 32-bit registers and sends each as a 7-byte 8N1 sync frame
// (header, addr, data LSB first, xor checksum) followed by an idle gap.
module uart_sync_frame_tx #(
    parameter int         UART_BAUD_RATE = 115200,
    parameter int         CLK_FREQ       = 100_000_000,
    parameter int         GAP_BITS       = 2,
    parameter logic [7:0] HEADER         = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    uart_sync_frame_tx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD_RATE;
    localparam int GAP_CYCLES   = GAP_BITS * CLKS_PER_BIT;
    localparam int FRAME_BITS   = 70;
    localparam int CNT_MAX      = (GAP_CYCLES > CLKS_PER_BIT) ? GAP_CYCLES : CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CNT_MAX);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SEND, GAP, FINISH} state_t;

    state_t      state;
    state_t      state_next;
    logic [CNT_W-1:0] cyc_cnt;
    logic [6:0]  bit_idx;
    logic [68:0] shifter;
    logic [8:0]  remain;
    logic [7:0]  addr;
    logic        txd;
    logic        busy_r;
    logic        done_r;
    logic        rd_req_r;
    logic [15:0] frames_sent_r;
    logic        bit_end;
    logic        gap_end;
    logic [7:0]  chk;
    logic [69:0] frame;

    assign bit_end = (cyc_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign gap_end = (GAP_CYCLES == 0) || (cyc_cnt == CNT_W'(GAP_CYCLES - 1));

    // Whole frame as a line-order bit vector: bit 0 is the header start bit.
    assign chk   = addr ^ bus.rd_data[7:0] ^ bus.rd_data[15:8]
                        ^ bus.rd_data[23:16] ^ bus.rd_data[31:24];
    assign frame = {1'b1, chk,                1'b0,
                    1'b1, bus.rd_data[31:24], 1'b0,
                    1'b1, bus.rd_data[23:16], 1'b0,
                    1'b1, bus.rd_data[15:8],  1'b0,
                    1'b1, bus.rd_data[7:0],   1'b0,
                    1'b1, addr,               1'b0,
                    1'b1, HEADER,             1'b0};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (bus.count == 9'd0) ? FINISH : RD_REQ;
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: if (bus.rd_valid) state_next = SEND;
            SEND:    if (bit_end && bit_idx == 7'(FRAME_BITS - 1)) state_next = GAP;
            GAP:     if (gap_end) state_next = (remain != 9'd0) ? RD_REQ : FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cyc_cnt       <= '0;
            bit_idx       <= '0;
            shifter       <= '0;
            remain        <= '0;
            addr          <= '0;
            txd           <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            rd_req_r      <= 1'b0;
            frames_sent_r <= '0;
        end else begin
            state    <= state_next;
            busy_r   <= (state_next == RD_REQ) || (state_next == RD_WAIT) ||
                        (state_next == SEND)   || (state_next == GAP);
            done_r   <= (state_next == FINISH);
            rd_req_r <= (state_next == RD_REQ);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr   <= bus.start_addr;
                        remain <= bus.count;
                    end
                end
                RD_WAIT: begin
                    if (bus.rd_valid) begin
                        txd     <= frame[0];
                        shifter <= frame[69:1];
                        bit_idx <= '0;
                        cyc_cnt <= '0;
                    end
                end
                SEND: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_idx == 7'(FRAME_BITS - 1)) begin
                            txd           <= 1'b1;
                            frames_sent_r <= frames_sent_r + 16'd1;
                            addr          <= addr + 8'd1;
                            remain        <= remain - 9'd1;
                        end else begin
                            txd     <= shifter[0];
                            shifter <= {1'b0, shifter[68:1]};
                            bit_idx <= bit_idx + 7'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                GAP: begin
                    cyc_cnt <= gap_end ? '0 : cyc_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.rd_req      = rd_req_r;
    assign bus.rd_addr     = addr;
    assign bus.uart_txd    = txd;
    assign bus.frames_sent = frames_sent_r;

endmodule

// File: tb/tb_uart_sync_frame_tx.sv
// Scoreboard bench: expected frames are queued when a range is started and a
// UART receiver process decodes the line and compares each frame it sees.
`timescale 1ns/1ps
module tb_uart_sync_frame_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 500_000;
    localparam int GAP_BITS  = 2;
    localparam int CPB       = CLK_FREQ / BAUD;
    localparam int FRAME_CYC = (70 + GAP_BITS) * CPB;

    logic clk = 1'b0;
    logic rst;
    uart_sync_frame_tx_if bus ();

    uart_sync_frame_tx #(
        .UART_BAUD_RATE (BAUD),
        .CLK_FREQ       (CLK_FREQ),
        .GAP_BITS       (GAP_BITS),
        .HEADER         (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rdreq_cnt = 0;
    int txd_low_cnt = 0;
    int frame_start_cyc = 0;
    int lat_force = -1;
    logic [15:0] exp_fs = '0;
    logic [31:0] bank [256];
    logic [55:0] exp_frame_q [$];
    logic [7:0]  rd_exp_q [$];

    bit          rx_active = 0;
    int          rx_t = 0;
    int          rx_bi = 0;
    logic [7:0]  rx_byte;
    logic [55:0] rx_frame;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Serial receiver: samples mid-bit, rebuilds bytes and frames.
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.rd_req) rdreq_cnt++;
        if (bus.uart_txd === 1'b0) txd_low_cnt++;
        if (rst) begin
            rx_active = 0;
            rx_bi = 0;
        end else if (!rx_active) begin
            if (bus.uart_txd === 1'b0) begin
                rx_active = 1;
                rx_t = 0;
                if (rx_bi == 0) frame_start_cyc = cyc;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2) begin
                int k;
                k = rx_t / CPB;
                if (k == 0) begin
                    if (bus.uart_txd !== 1'b0) begin
                        check_output("start_bit", bus.uart_txd, 0);
                        rx_active = 0;
                    end
                end else if (k <= 8) begin
                    rx_byte[k-1] = bus.uart_txd;
                end else begin
                    check_output("stop_bit", bus.uart_txd, 1);
                    rx_active = 0;
                    rx_frame = {rx_frame[47:0], rx_byte};
                    rx_bi++;
                    if (rx_bi == 7) begin
                        rx_bi = 0;
                        if (exp_frame_q.size() == 0) begin
                            n_vec++;
                            n_miss++;
                            $display("[TB] FAIL frame_unexpected: got %014h, expected none", rx_frame);
                        end else begin
                            check_output("frame", rx_frame, exp_frame_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Register bank responder with variable read latency.
    initial begin
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.rd_req === 1'b1) begin
                logic [7:0] a;
                int lat;
                a = bus.rd_addr;
                if (rd_exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL rd_unexpected: got %0h, expected none", a);
                end else begin
                    check_output("rd_addr", a, rd_exp_q.pop_front());
                end
                lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
                repeat (lat + 1) @(posedge clk);
                #2;
                bus.rd_valid = 1'b1;
                bus.rd_data  = bank[a];
                tick();
                bus.rd_valid = 1'b0;
                bus.rd_data  = $urandom;
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] a, input logic [8:0] c, input bit accept);
        if (accept) begin
            for (int i = 0; i < int'(c); i++) begin
                logic [7:0]  ea;
                logic [31:0] d;
                logic [7:0]  ck;
                ea = 8'((int'(a) + i) % 256);
                d  = bank[ea];
                ck = ea ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
                exp_frame_q.push_back({8'hA5, ea, d[7:0], d[15:8], d[23:16], d[31:24], ck});
                rd_exp_q.push_back(ea);
            end
            exp_fs = exp_fs + 16'(c);
        end
        bus.start_addr = a;
        bus.count      = c;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int c, input int base);
        int budget;
        bit got;
        budget = c * (FRAME_CYC + 20) + 50;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done_cnt > base) got = 1;
        end
        check_output("done_seen", got, 1);
        repeat (10) tick();
        check_output("done_pulses", done_cnt - base, 1);
        check_output("frames_sent", bus.frames_sent, exp_fs);
        check_output("frames_pending", exp_frame_q.size(), 0);
        check_output("reads_pending", rd_exp_q.size(), 0);
        check_output("busy_end", bus.busy, 0);
    endtask

    task automatic run_range(input logic [7:0] a, input logic [8:0] c);
        int base;
        base = done_cnt;
        apply_stimulus(a, c, 1);
        check_output("busy_after_start", bus.busy, (c != 0));
        wait_done(int'(c), base);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_frame_q.delete();
        rd_exp_q.delete();
        exp_fs = '0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int rq0;
        int tl0;
        bit found;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.count = '0;
        for (int i = 0; i < 256; i++) bank[i] = $urandom;
        repeat (3) tick();
        rst = 1'b0;
        check_output("reset_txd", bus.uart_txd, 1);
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_done", bus.done, 0);
        check_output("reset_rd_req", bus.rd_req, 0);
        check_output("reset_rd_addr", bus.rd_addr, 0);
        check_output("reset_frames_sent", bus.frames_sent, 0);

        $display("[TB] single frame");
        bank[8'h10] = 32'h1234_5678;
        lat_force = 3;
        run_range(8'h10, 9'd1);
        check_output("frame_to_done", done_cyc - frame_start_cyc, FRAME_CYC);
        lat_force = -1;

        $display("[TB] address wrap");
        run_range(8'hFE, 9'd3);

        $display("[TB] zero count");
        rq0 = rdreq_cnt;
        tl0 = txd_low_cnt;
        run_range(8'h20, 9'd0);
        check_output("zero_rd_req", rdreq_cnt - rq0, 0);
        check_output("zero_txd_low", txd_low_cnt - tl0, 0);

        $display("[TB] start while busy");
        base = done_cnt;
        apply_stimulus(8'h30, 9'd2, 1);
        repeat (100) tick();
        apply_stimulus(8'h40, 9'd5, 0);
        wait_done(2, base);

        $display("[TB] reset mid-frame");
        apply_stimulus(8'h80, 9'd2, 1);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (rx_active && rx_bi == 2) found = 1;
        end
        check_output("reached_data_byte", found, 1);
        do_reset();
        check_output("midreset_txd", bus.uart_txd, 1);
        check_output("midreset_busy", bus.busy, 0);
        check_output("midreset_frames_sent", bus.frames_sent, 0);
        repeat (10) tick();
        run_range(8'h01, 9'd1);

        $display("[TB] random ranges");
        for (int r = 0; r < 3; r++) begin
            run_range(8'($urandom_range(0, 255)), 9'($urandom_range(1, 4)));
        end

        $display("[TB] full 256-register range");
        for (int i = 0; i < 256; i++) bank[i] = 32'(i);
        do_reset();
        repeat (5) tick();
        run_range(8'h00, 9'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
